fpu_conv_sched: RTL and testbench
=================================

Name: fpu_conv_sched

Overview:
- Round-robin scheduler that shares one float-to-int conversion unit between two requesters: requester 0 is the core issue stage, requester 1 is the auxiliary/vector issue slot.
- Accepts ops over valid/ready, drives the unit's operand, mode and enable, and tracks in-flight ops in a LAT-deep shadow pipeline.
- Returns each result with its tag to the requester that issued it.
- Supports a flush that squashes in-flight results. Sits between the issue stages and the FPU conversion unit.

Parameters:
- LAT, 1: conversion-unit latency, cycles from unit_en high to unit_ready high. Legal range 1..4.
- TAG_W, 4: width of the requester tag carried alongside each op.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester op valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; combinational.
- req_a  in  2x32  per-requester float operand.
- req_mode  in  2  per-requester rounding mode: 0 = to nearest, 1 = toward down.
- req_tag  in  2xTAG_W  per-requester tag.
- unit_a  out  32  operand to the conversion unit (registered).
- unit_mode  out  1  mode to the unit (registered).
- unit_en  out  1  one-cycle issue strobe to the unit (registered).
- unit_res  in  32  unit result.
- unit_ready  in  1  unit result-valid strobe.
- flush  in  1  squash all in-flight ops and block acceptance this cycle.
- resp_valid  out  2  per-requester result valid (registered, one-cycle pulse, no backpressure).
- resp_data  out  32  result, shared bus, qualified by resp_valid.
- resp_tag  out  TAG_W  tag of the returned op.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rstn low, asynchronous) clears unit_en, resp_valid, err and all shadow-pipe valid bits. It also clears unit_a, unit_mode, resp_data and resp_tag, and sets the round-robin pointer last_grant to 1, so requester 0 wins the first contention.
- Grant logic:
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
  - req_ready[i] = grant[i] & ~flush.
  - At most one accept per cycle. last_grant updates only on an accept.
- Issue timing: an accept on the edge ending cycle N drives unit_en=1 with unit_a/unit_mode held from the accepted op during cycle N+1. unit_en is low in every cycle that did not follow an accept. Back-to-back accepts give a unit_en on consecutive cycles (full throughput).
- Shadow pipe:
  - LAT+1 stages holding {valid, requester id, tag}.
  - Stage 0 loads on accept; each stage shifts every cycle.
  - The last stage aligns with unit_ready (cycle N+1+LAT).
- Response:
  - On the cycle the last stage is valid and unit_ready=1, register resp_valid[id]=1, resp_data=unit_res, resp_tag=tag.
  - The response is visible in cycle N+2+LAT (N+3 for LAT=1).
- Flush:
  - flush=1 clears every shadow-pipe valid bit on that edge and forces req_ready=0.
  - The unit is not stalled. Its later unit_ready pulses for squashed ops are ignored and do not raise err.
  - A response already registered in the flush cycle still appears.
  - An op accepted the cycle after flush deasserts proceeds normally.
- err:
  - Set when unit_ready=1 while the last stage is invalid and no squash is outstanding, or when the last stage is valid and unit_ready=0.
  - Track squashed ops with a counter of width clog2(LAT+2). The counter is incremented by the number of valid stages killed and decremented on each unmatched unit_ready.
  - err is cleared only by reset.
- Reset mid-operation: all in-flight state is dropped. Any unit_ready after reset release with an empty pipe and a zero squash count sets err. Integration must reset the unit together with this block.
- Simultaneous accept and response in the same cycle are independent; no conflict.

Decomposition:
- Package fpu_pkg holds:
  - mode constants MODE_TO_NEAREST=0 and MODE_TOWARD_DOWN=1;
  - a struct-like constant set for the shadow entry {valid, id, tag};
  - the default LAT for each FPU unit.
- Sub-module rr_arb2: a 2-way round-robin arbiter with a last-grant register, reused later for fadd/fmul sharing.

Test Plan:
- Single op, LAT=1: req_valid=01, a=0x3FC00000 (1.5), mode 0, tag 5, accepted at cycle 0 -> unit_en at cycle 1; with the unit model returning 2, resp_valid=01, resp_data=2, resp_tag=5 at cycle 3.
- Contention: both valid for 4 cycles -> grants alternate 0,1,0,1; four responses return in the same order with matching tags; unit_en high for 4 consecutive cycles.
- Flush: accept tags 1,2 back-to-back, assert flush the cycle after the second accept -> no resp_valid for either tag, req_ready=00 during flush, err stays 0.
- Post-flush issue: op with tag 7 accepted the cycle after flush -> response with tag 7 at N+3; no spurious extra responses.
- Protocol error: inject unit_ready with the pipe empty -> err=1 the next cycle and remains 1 until rstn low.
- Async reset mid-flight: drop rstn between clock edges with 2 ops in flight -> all outputs zero immediately; no responses after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, shadow-entry field layout, unit latencies.
package fpu_pkg;

  localparam logic MODE_TO_NEAREST  = 1'b0;
  localparam logic MODE_TOWARD_DOWN = 1'b1;

  // Shadow entry packs as {tag, id, valid}, LSB first.
  localparam int SH_VALID = 0;
  localparam int SH_ID    = 1;
  localparam int SH_TAG   = 2;

  localparam int LAT_FCVT = 1;
  localparam int LAT_FADD = 3;
  localparam int LAT_FMUL = 4;

  function automatic int sh_width(int tag_w);
    return tag_w + 2;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when the caller reports an accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)    last_grant <= 1'b1;
    else if (adv) last_grant <= grant[1];

endmodule

// File: rtl/fpu_conv_sched.sv
// Shares one float-to-int unit between two issuers; a shadow pipe tracks in-flight
// ops so results return to their owner, and flushed ops are absorbed by a squash count.
module fpu_conv_sched
  import fpu_pkg::*;
#(
  parameter int LAT   = LAT_FCVT,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_a,
  input  logic [1:0]            req_mode,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [31:0]           unit_a,
  output logic                  unit_mode,
  output logic                  unit_en,
  input  logic [31:0]           unit_res,
  input  logic                  unit_ready,
  input  logic                  flush,
  output logic [1:0]            resp_valid,
  output logic [31:0]           resp_data,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  err
);

  localparam int SH_W = sh_width(TAG_W);
  localparam int CW   = $clog2(LAT + 2);

  logic [1:0]            grant;
  logic                  accept;
  logic                  gid;
  logic [SH_W-1:0]       sh_in;
  logic [LAT:0][SH_W-1:0] sh;
  logic                  last_v;
  logic                  last_id;
  logic [TAG_W-1:0]      last_tag;
  logic                  ready_unm;
  logic [CW-1:0]         kill;
  logic [CW-1:0]         sq_cnt;
  logic [CW-1:0]         sq_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req_valid),
    .adv   (accept),
    .grant (grant)
  );

  assign req_ready = grant & {2{~flush}};
  assign accept    = |(req_valid & req_ready);
  assign gid       = grant[1];

  always_comb begin
    sh_in                    = '0;
    sh_in[SH_VALID]          = accept;
    sh_in[SH_ID]             = gid;
    sh_in[SH_TAG +: TAG_W]   = req_tag[gid];
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      unit_en   <= 1'b0;
      unit_a    <= '0;
      unit_mode <= 1'b0;
    end else begin
      unit_en <= accept;
      if (accept) begin
        unit_a    <= req_a[gid];
        unit_mode <= req_mode[gid];
      end
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sh <= '0;
    else begin
      sh[0] <= sh_in;
      for (int k = 1; k <= LAT; k++) sh[k] <= sh[k-1];
      if (flush)
        for (int k = 0; k <= LAT; k++) sh[k][SH_VALID] <= 1'b0;
    end

  assign last_v    = sh[LAT][SH_VALID];
  assign last_id   = sh[LAT][SH_ID];
  assign last_tag  = sh[LAT][SH_TAG +: TAG_W];
  assign ready_unm = unit_ready & ~last_v;

  // The last stage still pairs with this cycle's unit_ready, so only earlier
  // stages owe a future pulse when flushed.
  always_comb begin
    kill = '0;
    for (int k = 0; k < LAT; k++) kill = kill + CW'(sh[k][SH_VALID]);
    sq_nxt = sq_cnt + (flush ? kill : '0) - CW'(ready_unm && (sq_cnt != '0));
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sq_cnt <= '0;
      err    <= 1'b0;
    end else begin
      sq_cnt <= sq_nxt;
      if ((ready_unm && sq_cnt == '0) || (last_v && !unit_ready)) err <= 1'b1;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else begin
      resp_valid <= '0;
      if (last_v && unit_ready && !flush) begin
        resp_valid[last_id] <= 1'b1;
        resp_data           <= unit_res;
        resp_tag            <= last_tag;
      end
    end

endmodule

// File: tb/tb_fpu_conv_sched.sv
// Bench for fpu_conv_sched: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model with a behavioural unit.
module tb_fpu_conv_sched;
  import fpu_pkg::*;

  localparam int LAT   = 1;
  localparam int TAG_W = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]            req_valid, req_ready, req_mode, resp_valid;
  logic [1:0][31:0]      req_a;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [31:0]           unit_a, unit_res, resp_data;
  logic                  unit_mode, unit_en, unit_ready, flush, err, inj;
  logic [TAG_W-1:0]      resp_tag;
  logic [LAT-1:0]        en_sr;
  logic [LAT-1:0][31:0]  res_sr;

  fpu_conv_sched #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_mode(req_mode), .req_tag(req_tag),
    .unit_a(unit_a), .unit_mode(unit_mode), .unit_en(unit_en),
    .unit_res(unit_res), .unit_ready(unit_ready), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag), .err(err)
  );

  // Positive float to integer; mode 0 rounds to nearest-even, mode 1 toward -inf.
  function automatic logic [31:0] cvt(logic [31:0] a, logic m);
    int sh;
    logic [31:0] mant, ip, rem, half;
    sh   = 150 - int'(a[30:23]);
    mant = {8'd0, 1'b1, a[22:0]};
    if (sh < 1)  return mant;
    if (sh > 24) return 32'd0;
    ip   = mant >> sh;
    rem  = mant & ((32'd1 << sh) - 32'd1);
    half = 32'd1 << (sh - 1);
    if (m) return ip;
    if (rem > half || (rem == half && ip[0])) return ip + 32'd1;
    return ip;
  endfunction

  function automatic logic [31:0] rnd_a();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom();
    e = 8'($urandom_range(127, 149));
    return {1'b0, e, r[22:0]};
  endfunction

  // Fixed-latency conversion unit, reset together with the scheduler.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      en_sr  <= '0;
      res_sr <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        en_sr[k]  <= en_sr[k-1];
        res_sr[k] <= res_sr[k-1];
      end
      en_sr[0]  <= unit_en;
      res_sr[0] <= cvt(unit_a, unit_mode);
    end
  assign unit_ready = en_sr[LAT-1] | inj;
  assign unit_res   = res_sr[LAT-1];

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle();
    req_valid = '0; req_mode = '0; req_a = '0; req_tag = '0; flush = 1'b0; inj = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
  endtask

  task automatic chk_resp(input string nm, input logic [1:0] v, input logic [31:0] d,
                          input logic [TAG_W-1:0] t);
    chk({nm, "_valid"}, 64'(resp_valid), 64'(v));
    if (v != 2'b00) begin
      chk({nm, "_data"}, 64'(resp_data), 64'(d));
      chk({nm, "_tag"},  64'(resp_tag),  64'(t));
    end
  endtask

  typedef struct {
    logic [1:0] v;
    logic       fl;
    logic [1:0] rdy;
    logic       en;
  } vec_t;

  typedef struct {
    int               due;
    int               id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  vec_t tbl[11];
  exp_t q[$];

  initial begin
    logic [31:0]      gd[4];
    logic [TAG_W-1:0] gt[4];
    logic [31:0]      a_keep;
    logic             mlast, acc, prev_acc;
    logic [1:0]       g, erdy;
    exp_t             e;

    // --- reset state ---
    do_reset();
    chk("rst_unit_en", 64'(unit_en), 0);
    chk("rst_unit_a", 64'(unit_a), 0);
    chk("rst_unit_mode", 64'(unit_mode), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_data", 64'(resp_data), 0);
    chk("rst_resp_tag", 64'(resp_tag), 0);
    chk("rst_err", 64'(err), 0);

    // --- arbitration table, applied cycle by cycle from reset ---
    tbl[0]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 2'b10, 1'b1};
    tbl[2]  = '{2'b01, 1'b0, 2'b01, 1'b1};
    tbl[3]  = '{2'b01, 1'b0, 2'b01, 1'b1};
    tbl[4]  = '{2'b11, 1'b0, 2'b10, 1'b1};
    tbl[5]  = '{2'b10, 1'b0, 2'b10, 1'b1};
    tbl[6]  = '{2'b11, 1'b1, 2'b00, 1'b1};
    tbl[7]  = '{2'b11, 1'b0, 2'b01, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 2'b00, 1'b1};
    tbl[9]  = '{2'b11, 1'b0, 2'b10, 1'b0};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b1};
    for (int i = 0; i < 11; i++) begin
      chk("tbl_unit_en", 64'(unit_en), 64'(tbl[i].en));
      req_valid = tbl[i].v; flush = tbl[i].fl;
      req_a[0] = rnd_a(); req_a[1] = rnd_a();
      req_tag[0] = TAG_W'(i); req_tag[1] = TAG_W'(i + 3);
      #1;
      chk("tbl_req_ready", 64'(req_ready), 64'(tbl[i].rdy));
      step();
    end
    idle();
    repeat (4) step();
    chk("tbl_err", 64'(err), 0);

    // --- single op: 1.5 to nearest -> 2, response at cycle 3 ---
    do_reset();
    req_valid = 2'b01; req_a[0] = 32'h3FC00000; req_mode[0] = MODE_TO_NEAREST; req_tag[0] = 4'd5;
    #1;
    chk("single_ready", 64'(req_ready), 64'(2'b01));
    step(); idle();
    chk("single_en_c1", 64'(unit_en), 1);
    chk("single_unit_a", 64'(unit_a), 64'h3FC00000);
    chk("single_unit_mode", 64'(unit_mode), 0);
    chk_resp("single_c1", 2'b00, '0, '0);
    step();
    chk("single_en_c2", 64'(unit_en), 0);
    chk_resp("single_c2", 2'b00, '0, '0);
    step();
    chk_resp("single_c3", 2'b01, 32'd2, 4'd5);
    step();
    chk_resp("single_c4", 2'b00, '0, '0);

    // --- contention: four cycles of both valid ---
    do_reset();
    for (int c = 0; c < 8; c++) begin
      chk("cont_unit_en", 64'(unit_en), 64'(c >= 1 && c <= 4));
      if (c >= 3 && c <= 6) chk_resp("cont_resp", ((c - 3) % 2) ? 2'b10 : 2'b01, gd[c-3], gt[c-3]);
      else                  chk_resp("cont_idle", 2'b00, '0, '0);
      if (c < 4) begin
        req_valid = 2'b11;
        req_a[0] = rnd_a(); req_a[1] = rnd_a();
        req_mode = 2'($urandom_range(0, 3));
        req_tag[0] = TAG_W'(c); req_tag[1] = TAG_W'(8 + c);
        gd[c] = cvt(req_a[c % 2], req_mode[c % 2]);
        gt[c] = req_tag[c % 2];
        #1;
        chk("cont_ready", 64'(req_ready), (c % 2) ? 64'(2'b10) : 64'(2'b01));
      end else idle();
      step();
    end

    // --- flush squashes two in-flight ops, then a fresh op proceeds ---
    do_reset();
    req_valid = 2'b01; req_a[0] = rnd_a(); req_tag[0] = 4'd1;
    step();
    req_a[0] = rnd_a(); req_tag[0] = 4'd2;
    step();
    chk_resp("flush_c2", 2'b00, '0, '0);
    flush = 1'b1; req_tag[0] = 4'd9;
    #1;
    chk("flush_ready", 64'(req_ready), 64'(2'b00));
    step();
    chk_resp("flush_c3", 2'b00, '0, '0);
    flush = 1'b0; req_a[0] = rnd_a(); req_mode[0] = MODE_TOWARD_DOWN; req_tag[0] = 4'd7;
    a_keep = req_a[0];
    #1;
    chk("postflush_ready", 64'(req_ready), 64'(2'b01));
    step(); idle();
    chk_resp("flush_c4", 2'b00, '0, '0);
    step();
    chk_resp("flush_c5", 2'b00, '0, '0);
    step();
    chk_resp("postflush_resp", 2'b01, cvt(a_keep, MODE_TOWARD_DOWN), 4'd7);
    step();
    chk_resp("postflush_c7", 2'b00, '0, '0);
    repeat (3) begin step(); chk_resp("postflush_quiet", 2'b00, '0, '0); end
    chk("flush_err", 64'(err), 0);

    // --- spurious unit_ready sets a sticky err ---
    do_reset();
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("perr_set", 64'(err), 1);
    repeat (3) step();
    chk("perr_sticky", 64'(err), 1);
    do_reset();
    chk("perr_cleared", 64'(err), 0);

    // --- asynchronous reset with two ops in flight ---
    do_reset();
    req_valid = 2'b01; req_a[0] = rnd_a(); req_tag[0] = 4'd3;
    step();
    req_a[0] = rnd_a(); req_tag[0] = 4'd4;
    step();
    idle();
    #2 rstn = 1'b0;
    #1;
    chk("arst_unit_en", 64'(unit_en), 0);
    chk("arst_unit_a", 64'(unit_a), 0);
    chk("arst_resp_valid", 64'(resp_valid), 0);
    chk("arst_resp_data", 64'(resp_data), 0);
    chk("arst_err", 64'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) begin
      step();
      chk("arst_no_resp", 64'(resp_valid), 0);
    end
    chk("arst_err_after", 64'(err), 0);

    // --- randomized run against the reference model ---
    do_reset();
    q.delete();
    mlast = 1'b1; prev_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk_resp("rnd_resp", (e.id == 1) ? 2'b10 : 2'b01, e.data, e.tag);
      end else chk_resp("rnd_idle", 2'b00, '0, '0);
      chk("rnd_unit_en", 64'(unit_en), 64'(prev_acc));
      req_valid = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 11) == 0);
      req_a[0] = rnd_a(); req_a[1] = rnd_a();
      req_mode  = 2'($urandom_range(0, 3));
      req_tag[0] = TAG_W'($urandom()); req_tag[1] = TAG_W'($urandom());
      #1;
      case (req_valid)
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = mlast ? 2'b01 : 2'b10;
        default: g = 2'b00;
      endcase
      erdy = flush ? 2'b00 : g;
      chk("rnd_ready", 64'(req_ready), 64'(erdy));
      // A flush drops every op whose result has not yet been returned.
      if (flush) while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
      acc = |(req_valid & erdy);
      if (acc) begin
        e.due  = cyc + LAT + 2;
        e.id   = erdy[1] ? 1 : 0;
        e.tag  = req_tag[e.id];
        e.data = cvt(req_a[e.id], req_mode[e.id]);
        q.push_back(e);
        mlast = erdy[1];
      end
      prev_acc = acc;
      step();
    end
    idle();
    for (int n = 0; n < LAT + 4; n++) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk_resp("drain_resp", (e.id == 1) ? 2'b10 : 2'b01, e.data, e.tag);
      end else chk_resp("drain_idle", 2'b00, '0, '0);
      step();
    end
    chk("rnd_queue_empty", 64'(q.size()), 0);
    chk("rnd_err", 64'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
